// File: rtl/controle_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes,
// ALU operand/operation selects and the control output bundle.
package controle_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_R   = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_EXEC_I = 4'd9,
    S_WB_I   = 4'd10,
    S_ILEGAL = 4'd15
  } estado_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Every datapath select/enable driven by the control unit
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/controle_saidas.sv
// Combinational decode from the current state (and memory ready, for the
// fetch-time IR/PC load) to the control output bundle.
module controle_saidas
  import controle_pkg::*;
(
  input  logic [ST_W-1:0] estado_i,
  input  logic            memPronta_i,
  output ctrl_t           ctrl_o
);

  // Anything not listed for a state stays 0; unused encodings drive nothing
  always_comb begin
    ctrl_o = '0;
    case (estado_i)
      S_FETCH: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.aluSrcB = SRCB_4;
        ctrl_o.aluOp   = ALUOP_ADD;
        // IR load and PC+4 commit only on the cycle the read completes
        ctrl_o.irWrite = memPronta_i;
        ctrl_o.pcWrite = memPronta_i;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB = SRCB_IMMSH;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_B;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl_o.regDst   = 1'b1;
        ctrl_o.regWrite = 1'b1;
      end
      S_ADDR: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.memToReg = 1'b1;
        ctrl_o.regWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluSrcB     = SRCB_B;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_WB_I: begin
        ctrl_o.regWrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control unit: state register, opcode-driven sequencing
// and sticky illegal-opcode flag. Output decode lives in controle_saidas.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               memPronta,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memToReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               excecao,
  output logic [3:0]         estado
);

  logic [ST_W-1:0] estado_q, estado_d;
  logic            excecao_q, excecao_d;
  ctrl_t           ctrl;

  // The branch condition is applied in the datapath (pcWriteCond & zero)
  logic unused_zero;
  assign unused_zero = zero;

  // Next-state sequencing; any unknown encoding falls into ILEGAL
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      S_FETCH:  if (memPronta) estado_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_W'(OP_RTYPE))                                 estado_d = S_EXEC_R;
        else if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW))     estado_d = S_ADDR;
        else if (opcode == OP_W'(OP_BEQ))                              estado_d = S_BRANCH;
        else if (opcode == OP_W'(OP_ADDI))                             estado_d = S_EXEC_I;
        else                                                           estado_d = S_ILEGAL;
      end
      S_EXEC_R: estado_d = S_WB_R;
      S_WB_R:   estado_d = S_FETCH;
      // IR is frozen (irWrite=0), so the opcode is still the one decoded
      S_ADDR: begin
        if (opcode == OP_W'(OP_LW))      estado_d = S_MEM_RD;
        else if (opcode == OP_W'(OP_SW)) estado_d = S_MEM_WR;
        else                             estado_d = S_ILEGAL;
      end
      S_MEM_RD: if (memPronta) estado_d = S_WB_MEM;
      S_MEM_WR: if (memPronta) estado_d = S_FETCH;
      S_WB_MEM: estado_d = S_FETCH;
      S_BRANCH: estado_d = S_FETCH;
      S_EXEC_I: estado_d = S_WB_I;
      S_WB_I:   estado_d = S_FETCH;
      S_ILEGAL: estado_d = S_ILEGAL;
      default:  estado_d = S_ILEGAL;
    endcase
  end

  // Exception flag rises together with entry into ILEGAL and sticks
  assign excecao_d = excecao_q | (estado_d == S_ILEGAL);

  // State and exception registers, synchronous reset aborts any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= S_FETCH;
      excecao_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      excecao_q <= excecao_d;
    end
  end

  controle_saidas u_saidas (
    .estado_i    (estado_q),
    .memPronta_i (memPronta),
    .ctrl_o      (ctrl)
  );

  // Reset silences every output so no write escapes an aborted instruction
  assign pcWrite     = ~reset & ctrl.pcWrite;
  assign pcWriteCond = ~reset & ctrl.pcWriteCond;
  assign iorD        = ~reset & ctrl.iorD;
  assign memRead     = ~reset & ctrl.memRead;
  assign memWrite    = ~reset & ctrl.memWrite;
  assign irWrite     = ~reset & ctrl.irWrite;
  assign memToReg    = ~reset & ctrl.memToReg;
  assign regDst      = ~reset & ctrl.regDst;
  assign regWrite    = ~reset & ctrl.regWrite;
  assign aluSrcA     = ~reset & ctrl.aluSrcA;
  assign aluSrcB     = reset ? 2'b00 : ctrl.aluSrcB;
  assign aluOp       = reset ? '0 : ALUOP_W'(ctrl.aluOp);
  assign excecao     = ~reset & excecao_q;
  assign estado      = reset ? 4'd0 : estado_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed vector table for the listed
// sequences, then random instruction streams built from per-instruction
// state scripts with random memory wait counts.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset, zero, memPronta;
  logic [5:0] opcode;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, excecao;
  logic [1:0] aluSrcB, aluOp;
  logic [3:0] estado;

  always #5 clk = ~clk;

  controle_multiciclo #(.OP_W(6), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memPronta(memPronta),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .excecao(excecao), .estado(estado)
  );

  typedef struct packed {
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp;
  } o_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       z, mp;
    logic [3:0] st;
    logic       exc;
  } vec_t;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;

  o_t   outtab [16];
  vec_t tbl[$];
  int   nvec = 0, nerr = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic mp, input logic [3:0] st, input logic exc);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.mp = mp; v.st = st; v.exc = exc;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, check the outputs of the current state, advance
  task automatic apply(input logic r, input logic [5:0] op, input logic z,
                       input logic mp, input logic [3:0] st, input logic exc,
                       input string tag);
    logic [18:0] expv, got;
    o_t o;
    reset = r; opcode = op; zero = z; memPronta = mp;
    #4;
    if (r) expv = '0;
    else begin
      o = outtab[st];
      if (st == 4'd0) begin o.irWrite = mp; o.pcWrite = mp; end
      expv = {o, exc, st};
    end
    got = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, excecao, estado};
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s vec%0d: got %05h expected %05h", tag, nvec, got, expv);
    end
    @(posedge clk); #1;
  endtask

  logic [3:0] sq[$];
  logic       mq[$];

  task automatic push_wait(input logic [3:0] st, input int w);
    for (int k = 0; k < w; k++) begin sq.push_back(st); mq.push_back(1'b0); end
    sq.push_back(st); mq.push_back(1'b1);
  endtask

  task automatic push_any(input logic [3:0] st);
    sq.push_back(st); mq.push_back(1'($urandom_range(0, 1)));
  endtask

  initial begin
    for (int s = 0; s < 16; s++) outtab[s] = '0;
    outtab[0].memRead = 1; outtab[0].aluSrcB = 2'b01;
    outtab[1].aluSrcB = 2'b11;
    outtab[2].aluSrcA = 1; outtab[2].aluOp = 2'b10;
    outtab[6].regDst = 1; outtab[6].regWrite = 1;
    outtab[3].aluSrcA = 1; outtab[3].aluSrcB = 2'b10;
    outtab[4].memRead = 1; outtab[4].iorD = 1;
    outtab[5].memWrite = 1; outtab[5].iorD = 1;
    outtab[7].memToReg = 1; outtab[7].regWrite = 1;
    outtab[8].aluSrcA = 1; outtab[8].aluOp = 2'b01; outtab[8].pcWriteCond = 1;
    outtab[9].aluSrcA = 1; outtab[9].aluSrcB = 2'b10;
    outtab[10].regWrite = 1;

    // Directed table
    add(1, R, 0, 0, 0, 0); add(1, R, 0, 0, 0, 0);
    add(0, R, 0, 1, 0, 0); add(0, R, 0, 1, 1, 0); add(0, R, 0, 1, 2, 0); add(0, R, 0, 1, 6, 0);
    add(0, LW, 0, 1, 0, 0); add(0, LW, 0, 1, 1, 0); add(0, LW, 0, 1, 3, 0);
    add(0, LW, 0, 0, 4, 0); add(0, LW, 0, 0, 4, 0); add(0, LW, 0, 0, 4, 0);
    add(0, LW, 0, 1, 4, 0); add(0, LW, 0, 1, 7, 0);
    add(0, SW, 0, 1, 0, 0); add(0, SW, 0, 1, 1, 0); add(0, SW, 0, 1, 3, 0); add(0, SW, 0, 1, 5, 0);
    add(0, BEQ, 1, 1, 0, 0); add(0, BEQ, 1, 1, 1, 0); add(0, BEQ, 1, 1, 8, 0);
    add(0, BEQ, 0, 1, 0, 0); add(0, BEQ, 0, 1, 1, 0); add(0, BEQ, 0, 1, 8, 0);
    add(0, ADDI, 0, 1, 0, 0); add(0, ADDI, 0, 1, 1, 0); add(0, ADDI, 0, 1, 9, 0); add(0, ADDI, 0, 1, 10, 0);
    add(0, BAD, 0, 1, 0, 0); add(0, BAD, 0, 1, 1, 0);
    for (int k = 0; k < 10; k++) add(0, BAD, 0, 1, 15, 1);
    add(1, BAD, 0, 1, 0, 0);
    add(0, R, 0, 0, 0, 0);
    add(0, R, 0, 1, 0, 0); add(0, R, 0, 1, 1, 0);
    add(1, R, 0, 1, 0, 0);                 // reset lands while in EXEC_R
    add(0, R, 0, 0, 0, 0);                 // back in FETCH, nothing written

    reset = 1; opcode = '0; zero = 0; memPronta = 0;
    @(posedge clk); #1;
    foreach (tbl[i])
      apply(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mp, tbl[i].st, tbl[i].exc, "table");

    // Random instruction streams; FSM is in FETCH here
    for (int i = 0; i < 80; i++) begin
      int cls;
      logic [5:0] op;
      logic abort;
      cls = $urandom_range(0, 11);
      abort = 0;
      sq.delete(); mq.delete();
      push_wait(4'd0, $urandom_range(0, 2));
      push_any(4'd1);
      case (cls)
        0, 1: begin op = R; push_any(4'd2); push_any(4'd6); end
        2, 3: begin op = LW; push_any(4'd3); push_wait(4'd4, $urandom_range(0, 3)); push_any(4'd7); end
        4, 5: begin op = SW; push_any(4'd3); push_wait(4'd5, $urandom_range(0, 3)); end
        6, 7: begin op = BEQ; push_any(4'd8); end
        8, 9: begin op = ADDI; push_any(4'd9); push_any(4'd10); end
        10: begin
          op = 6'($urandom);
          while (op == R || op == LW || op == SW || op == BEQ || op == ADDI) op = 6'($urandom);
          for (int k = 0; k < 3; k++) push_any(4'd15);
          abort = 1;
        end
        default: begin op = R; abort = 1; end
      endcase
      foreach (sq[k])
        apply(0, op, 1'($urandom_range(0, 1)), mq[k], sq[k], sq[k] == 4'd15, "random");
      if (abort) apply(1, op, 0, 1'($urandom_range(0, 1)), 4'd0, 0, "random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multi-cycle control unit for the MIPS-style datapath. It decodes the 6-bit opcode latched in the instruction register and steps the datapath through fetch, decode, execute, memory and write-back. It drives every datapath select and enable, including memToReg into the write-back mux, and stalls on a memory-ready handshake. It sits between the instruction register and the datapath muxes, register bank, ALU and memory.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 2, aluOp width to the ALU control

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
opcode  in  OP_W  instruction[31:26] from the instruction register
zero  in  1  ALU zero flag
memPronta  in  1  memory ready; the access completes in a cycle where it is 1
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if zero=1 (beq)
iorD  out  1  memory address select: 0=PC, 1=ALU out
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  instruction register load
memToReg  out  1  write-back select: 1=memory data, 0=ALU result
regDst  out  1  destination: 1=rd, 0=rt
regWrite  out  1  register bank write
aluSrcA  out  1  0=PC, 1=register A
aluSrcB  out  2  00=B, 01=const 4, 10=sign-extended immediate, 11=immediate<<2
aluOp  out  ALUOP_W  00=add, 01=sub, 10=use funct
excecao  out  1  sticky illegal-opcode flag
estado  out  4  current state, for debug

Behaviour:
- State register, 4 bits, encoded: FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_MEM=7, BRANCH=8, EXEC_I=9, WB_I=10, ILEGAL=15.
- reset=1 at a rising edge sets state to FETCH and clears excecao.
- While reset=1, every output is forced to 0.
- Each state's outputs list only the signals that are 1 (or nonzero). All other outputs are 0 in that state.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00. irWrite=pcWrite=memPronta. Stays in FETCH until memPronta=1, then goes to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next state by opcode:
  - 000000 → EXEC_R
  - 100011 (lw) or 101011 (sw) → ADDR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → EXEC_I
  - anything else → ILEGAL
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOp=10. Next: WB_R.
- WB_R: regDst=1, memToReg=0, regWrite=1. Next: FETCH.
- ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: MEM_RD for lw, MEM_WR for sw. The opcode is re-sampled here; the instruction register is stable because irWrite=0.
- MEM_RD: memRead=1, iorD=1. Holds until memPronta=1, then goes to WB_MEM.
- MEM_WR: memWrite=1, iorD=1. Holds until memPronta=1, then goes to FETCH.
- WB_MEM: regDst=0, memToReg=1, regWrite=1. Next: FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1. Next: FETCH. The effective PC write is pcWrite | (pcWriteCond & zero), gated in the datapath.
- EXEC_I: aluSrcA=1, aluSrcB=10, aluOp=00. Next: WB_I.
- WB_I: regDst=0, memToReg=0, regWrite=1. Next: FETCH.
- ILEGAL: all outputs 0, excecao=1. The state is absorbing until reset.
- Latency with memPronta tied to 1: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4. Each memory wait cycle adds 1.
- memRead and memWrite are never 1 in the same cycle.
- regWrite is never 1 in FETCH, DECODE or memory states.
- reset asserted mid-instruction aborts it. The next cycle is FETCH with no write issued.
- An unused state encoding goes to ILEGAL.

Decomposition:
- Shared package controle_pkg holds:
  - state encodings
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - aluSrcB constants SRCB_B, SRCB_4, SRCB_IMM, SRCB_IMMSH
  - aluOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
- Natural sub-module: controle_saidas, a combinational decode from (state, memPronta) to the output vector. The top keeps the state register and next-state logic.

Test Plan:
- reset=1 for 2 cycles, then opcode=000000, memPronta=1 → states 0,1,2,6,0. regWrite=1, regDst=1, memToReg=0 only in cycle 4.
- lw (100011), memPronta=0 for 3 cycles in MEM_RD → state held at 4 for 3 cycles, then 7. WB_MEM drives memToReg=1, regWrite=1. Total 8 cycles.
- sw (101011), memPronta=1 → states 0,1,3,5,0. memWrite=1, iorD=1 only in MEM_WR. regWrite=0 throughout.
- beq (000100), zero=1 then zero=0 → 3 cycles each. pcWriteCond=1 only in BRANCH. aluOp=01 in BRANCH.
- opcode=111111 → ILEGAL after DECODE. excecao=1 and all outputs 0 for 10 cycles. reset → FETCH, excecao=0.
- Assert reset during EXEC_R → next state FETCH. regWrite never 1 for the aborted instruction.
